// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the simple16 trace capture block: FSM encoding,
// capture-mode constants and the bit offsets of each field in a trace entry.
package cpu_trace_pkg;

    // Capture controller states; the numeric values are visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // cfg_mode values.
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_WRONLY   = 1'b1;

    // Default field widths for the simple16 core.
    localparam int TRC_TS_W   = 16;
    localparam int TRC_DATA_W = 16;
    localparam int TRC_ADDR_W = 3;

    // Entry layout, MSB to LSB: {ts, pc, alu_y, we, waddr, wdata}.
    // These offsets give the LSB position of each field.
    localparam int OFF_WDATA   = 0;
    localparam int OFF_WADDR   = OFF_WDATA + TRC_DATA_W;
    localparam int OFF_WE      = OFF_WADDR + TRC_ADDR_W;
    localparam int OFF_ALU     = OFF_WE + 1;
    localparam int OFF_PC      = OFF_ALU + TRC_DATA_W;
    localparam int OFF_TS      = OFF_PC + TRC_DATA_W;
    localparam int TRC_ENTRY_W = OFF_TS + TRC_TS_W;

    // Entry width for an arbitrary set of field widths.
    function automatic int entry_width(int ts_w, int data_w, int addr_w);
        return ts_w + 3 * data_w + addr_w + 1;
    endfunction

endpackage

// File: rtl/trace_ring.sv
// Ring buffer of trace entries. A push into a full ring overwrites the oldest
// entry (the read pointer moves along with the write pointer) and flags it on
// ovw_o. Flush clears pointers and count; storage is left untouched.
module trace_ring #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 68
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    ovw_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop, full, ovw;

    assign do_pop = pop_i && (count_q != '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign ovw    = push_i && full && !do_pop;

    // Pointer and occupancy next-state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop || ovw)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !ovw && !do_pop)
                count_d = count_q + 1'b1;
            else if (do_pop && !push_i)
                count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, not reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign ovw_o     = ovw && !flush_i;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace capture for the simple16 observation ports. Snapshots are timestamped
// and pushed into trace_ring while running, then streamed out oldest-first
// over a valid/ready port once capture is finished.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16,
    parameter int STRIDE_W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_W-1:0]                 obs_pc,
    input  logic [DATA_W-1:0]                 obs_alu_y,
    input  logic                              obs_reg_we,
    input  logic [ADDR_W-1:0]                 obs_reg_waddr,
    input  logic [DATA_W-1:0]                 obs_reg_wdata,
    input  logic                              cfg_mode,
    input  logic                              cfg_wrap,
    input  logic [STRIDE_W-1:0]               cfg_stride,
    input  logic                              arm,
    input  logic                              stop,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [TS_W+3*DATA_W+ADDR_W:0]     rd_data,
    output logic [1:0]                        state,
    output logic [$clog2(DEPTH):0]            count,
    output logic                              overflow
);
    localparam int ENTRY_W = TS_W + 3 * DATA_W + ADDR_W + 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    state_t              state_q, state_d;
    logic                mode_q, wrap_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [STRIDE_W-1:0] scnt_q, scnt_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic                ovf_q, ovf_d;

    logic                start, capture, push, pop, flush;
    logic                last_slot, valid_out;
    logic [ENTRY_W-1:0]  entry, ring_data;
    logic [CNT_W-1:0]    ring_count;
    logic                ring_ovw;

    assign entry     = {ts_q, obs_pc, obs_alu_y, obs_reg_we, obs_reg_waddr, obs_reg_wdata};
    assign last_slot = (ring_count == CNT_W'(DEPTH - 1));
    assign valid_out = (state_q == ST_DONE) && (ring_count != '0);

    // Capture qualification: stride counter at zero, or a register write.
    always_comb begin
        capture = 1'b0;
        if (state_q == ST_RUN)
            capture = (mode_q == MODE_WRONLY) ? obs_reg_we : (scnt_q == '0);
    end

    // FSM next-state and ring control.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                    flush   = 1'b1;
                end
            end
            ST_RUN: begin
                push = capture;
                // stop beats arm; the qualifying capture still goes in.
                if (stop)
                    state_d = ST_DONE;
                else if (capture && !wrap_q && last_slot)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                // arm discards what is left, even if a pop would also fire.
                if (arm) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                    flush   = 1'b1;
                end else if (valid_out && rd_ready) begin
                    pop = 1'b1;
                    if (ring_count == CNT_W'(1))
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timestamp, stride counter and sticky overflow next-state.
    always_comb begin
        ts_d   = ts_q;
        scnt_d = scnt_q;
        ovf_d  = ovf_q;
        if (start) begin
            ts_d   = '0;
            scnt_d = '0;
            ovf_d  = 1'b0;
        end else if (state_q == ST_RUN) begin
            ts_d = ts_q + 1'b1;
            if (mode_q == MODE_PERIODIC)
                scnt_d = (scnt_q >= stride_q - 1'b1) ? '0 : scnt_q + 1'b1;
            if (ring_ovw)
                ovf_d = 1'b1;
        end
    end

    // State, counters and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            scnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            scnt_q  <= scnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Configuration latched on the arm edge; a zero stride behaves as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_PERIODIC;
            wrap_q   <= 1'b0;
            stride_q <= STRIDE_W'(1);
        end else if (start) begin
            mode_q   <= cfg_mode;
            wrap_q   <= cfg_wrap;
            stride_q <= (cfg_stride == '0) ? STRIDE_W'(1) : cfg_stride;
        end
    end

    trace_ring #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .rd_data_o   (ring_data),
        .count_o     (ring_count),
        .ovw_o       (ring_ovw)
    );

    assign rd_valid = valid_out;
    assign rd_data  = valid_out ? ring_data : '0;
    assign state    = state_q;
    assign count    = ring_count;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with DEPTH=4. A queue-based model of
// the capture rules is advanced on every rising edge; a compare process
// checks all outputs against it at every falling edge, and literal checks
// pin the captured timestamps and register-write fields.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int DEPTH = 4;
    localparam int EW    = TRC_ENTRY_W;

    logic          clk, rst_n;
    logic [15:0]   obs_pc, obs_alu_y, obs_reg_wdata;
    logic          obs_reg_we;
    logic [2:0]    obs_reg_waddr;
    logic          cfg_mode, cfg_wrap;
    logic [7:0]    cfg_stride;
    logic          arm, stop, rd_ready;
    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [1:0]    state;
    logic [2:0]    count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // model state
    logic [EW-1:0] m_q[$];
    int            m_state;
    int            m_cyc;
    int            m_stride;
    bit            m_mode, m_wrap, m_ovf;

    cpu_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .obs_pc(obs_pc), .obs_alu_y(obs_alu_y), .obs_reg_we(obs_reg_we),
        .obs_reg_waddr(obs_reg_waddr), .obs_reg_wdata(obs_reg_wdata),
        .cfg_mode(cfg_mode), .cfg_wrap(cfg_wrap), .cfg_stride(cfg_stride),
        .arm(arm), .stop(stop),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .state(state), .count(count), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ts_of(input logic [EW-1:0] e);
        return int'(e[OFF_TS +: 16]);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_state = 0;
        m_cyc   = 0;
        m_ovf   = 0;
    endtask

    task automatic model_start();
        m_q.delete();
        m_state  = 1;
        m_cyc    = 0;
        m_ovf    = 0;
        m_mode   = cfg_mode;
        m_wrap   = cfg_wrap;
        m_stride = (cfg_stride == 0) ? 1 : int'(cfg_stride);
    endtask

    // One rising edge of the model, using the inputs present before the edge.
    task automatic model_edge();
        bit            cap;
        logic [EW-1:0] e;
        case (m_state)
            0: if (arm) model_start();
            1: begin
                cap = m_mode ? obs_reg_we : ((m_cyc % m_stride) == 0);
                if (cap) begin
                    e = {16'(m_cyc), obs_pc, obs_alu_y, obs_reg_we, obs_reg_waddr, obs_reg_wdata};
                    m_q.push_back(e);
                    if (m_q.size() > DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1;
                    end
                end
                m_cyc++;
                if (stop) m_state = 2;
                else if (!m_wrap && m_q.size() == DEPTH) m_state = 2;
            end
            default: begin
                if (arm) model_start();
                else if (rd_ready && m_q.size() > 0) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_state = 0;
                end
            end
        endcase
    endtask

    // Advance one clock; observation data moves on shortly after the edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        obs_pc    = obs_pc + 16'd4;
        obs_alu_y = obs_pc ^ 16'hA5C3;
    endtask

    // Every-cycle comparison against the model.
    initial begin
        logic          e_vld;
        logic [EW-1:0] e_dat;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_vld = (m_state == 2) && (m_q.size() > 0);
                e_dat = e_vld ? m_q[0] : '0;
                chk("state",    state,    m_state);
                chk("count",    count,    m_q.size());
                chk("overflow", overflow, m_ovf);
                chk("rd_valid", rd_valid, e_vld);
                chk("rd_data",  rd_data,  e_dat);
            end
        end
    end

    initial begin
        int e_ts[3];
        int e_wa[3];
        int e_wd[3];
        e_ts = '{2, 5, 9};
        e_wa = '{1, 2, 7};
        e_wd = '{16'h0005, 16'h00A0, 16'hFFFF};

        rst_n = 1'b0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
        cfg_mode = 1'b0; cfg_wrap = 1'b0; cfg_stride = 8'd1;
        obs_pc = 16'h0100; obs_alu_y = 16'h0000;
        obs_reg_we = 1'b0; obs_reg_waddr = 3'd3; obs_reg_wdata = 16'hBEEF;
        model_reset();
        chk_en = 1;
        #2;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_data", rd_data, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: periodic, one-shot, stride 10
        cfg_mode = 1'b0; cfg_wrap = 1'b0; cfg_stride = 8'd10;
        arm = 1'b1; step(); arm = 1'b0;
        cfg_stride = 8'd3;  // must not affect the run in progress
        repeat (40) step();
        chk("t1_state", state, 2);
        chk("t1_count", count, 4);
        chk("t1_ovf", overflow, 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_ts", ts_of(rd_data), i * 10);
            step();
        end
        rd_ready = 1'b0;
        chk("t1_idle", state, 0);

        // 2: write-only, one-shot, three writes then stop
        cfg_mode = 1'b1;
        arm = 1'b1; step(); arm = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            obs_reg_we = 1'b0;
            for (int j = 0; j < 3; j++)
                if (k == e_ts[j]) begin
                    obs_reg_we    = 1'b1;
                    obs_reg_waddr = 3'(e_wa[j]);
                    obs_reg_wdata = 16'(e_wd[j]);
                end
            stop = (k == 10);
            step();
        end
        obs_reg_we = 1'b0; stop = 1'b0;
        chk("t2_count", count, 3);
        chk("t2_state", state, 2);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_ts", ts_of(rd_data), e_ts[i]);
            chk("t2_waddr", rd_data[OFF_WADDR +: 3], e_wa[i]);
            chk("t2_wdata", rd_data[OFF_WDATA +: 16], e_wd[i]);
            step();
        end
        rd_ready = 1'b0;
        chk("t2_idle", state, 0);

        // 3: periodic, circular, stride 1; arm mid-run is ignored
        cfg_mode = 1'b0; cfg_wrap = 1'b1; cfg_stride = 8'd1;
        arm = 1'b1; step(); arm = 1'b0;
        for (int k = 0; k < 10; k++) begin
            arm  = (k == 4);
            stop = (k == 9);
            step();
        end
        arm = 1'b0; stop = 1'b0;
        chk("t3_count", count, 4);
        chk("t3_ovf", overflow, 1);
        chk("t3_state", state, 2);

        // 4: backpressure then alternate-cycle ready
        repeat (5) begin
            chk("t4_hold_ts", ts_of(rd_data), 6);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            rd_ready = (i % 2 == 0);
            if (rd_ready) chk("t4_pop_ts", ts_of(rd_data), 6 + i / 2);
            step();
        end
        rd_ready = 1'b0;
        chk("t4_idle", state, 0);
        chk("t4_count", count, 0);

        // 5: stride 0, stop with capture, arm in DONE
        cfg_mode = 1'b0; cfg_wrap = 1'b0; cfg_stride = 8'd0;
        arm = 1'b1; step(); arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stop = (k == 2);
            step();
        end
        stop = 1'b0;
        chk("t5_count", count, 3);
        chk("t5_state", state, 2);
        chk("t5_ts0", ts_of(rd_data), 0);
        rd_ready = 1'b1; step();
        chk("t5_count_pop", count, 2);
        chk("t5_ts1", ts_of(rd_data), 1);
        arm = 1'b1; step(); arm = 1'b0; rd_ready = 1'b0;
        chk("t5_rearm_count", count, 0);
        chk("t5_rearm_state", state, 1);

        // 6: reset mid-run, then a fresh arm
        step(); step();
        chk("t6_count", count, 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_vld", rd_valid, 0);
        chk("t6_rst_data", rd_data, 0);
        step();
        rst_n = 1'b1;
        cfg_stride = 8'd7;
        arm = 1'b1; step(); arm = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        chk("t6_count1", count, 1);
        chk("t6_done", state, 2);
        chk("t6_ts0", ts_of(rd_data), 0);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("t6_idle", state, 0);
        step();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
